// File: rtl/hack_cpu_mc.sv
// Multi-cycle Hack CPU: fetch, optional M read, one-cycle execute, optional M write.
// Instruction and data memories are reached through separate req/ack handshakes.
module hack_cpu_mc #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned ADDR_W   = 15,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              instr_req,
    output logic [ADDR_W-1:0] instr_addr,
    input  logic              instr_ack,
    input  logic [DATA_W-1:0] instr_data,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic [ADDR_W-1:0] pc_out,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] d_out,
    output logic              retire,
    output logic              halted
);

    localparam logic [ADDR_W-1:0] ResetPc = ADDR_W'(RESET_PC);

    typedef enum logic [2:0] {
        StFetch,
        StMemRd,
        StExec,
        StMemWr,
        StHalt
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] d_q, d_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] m_q, m_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic              halt_pend_q, halt_pend_d;
    logic              halted_q, halted_d;

    // Instruction field decode (C-instruction layout)
    logic              is_c;
    logic              sel_m;
    logic              dest_a, dest_d, dest_m;
    logic [2:0]        jmp_bits;

    assign is_c     = ir_q[DATA_W-1];
    assign sel_m    = ir_q[12];
    assign dest_a   = ir_q[5];
    assign dest_d   = ir_q[4];
    assign dest_m   = ir_q[3];
    assign jmp_bits = ir_q[2:0];

    logic [DATA_W-1:0] alu_x, alu_y, alu_r;
    logic              alu_zr, alu_ng;
    logic              jmp_taken;
    logic [ADDR_W-1:0] jmp_tgt;
    logic [ADDR_W-1:0] pc_inc;
    logic              halt_now;

    // ALU: x = D, y = A or M, with zx/nx/zy/ny/f/no control bits
    always_comb begin
        alu_x = ir_q[11] ? '0 : d_q;
        if (ir_q[10]) alu_x = ~alu_x;
        alu_y = ir_q[9] ? '0 : (sel_m ? m_q : a_q);
        if (ir_q[8]) alu_y = ~alu_y;
        alu_r = ir_q[7] ? (alu_x + alu_y) : (alu_x & alu_y);
        if (ir_q[6]) alu_r = ~alu_r;
    end

    assign alu_zr    = (alu_r == '0);
    assign alu_ng    = alu_r[DATA_W-1];
    assign jmp_taken = is_c && ((jmp_bits[2] && alu_ng) || (jmp_bits[1] && alu_zr) ||
                                (jmp_bits[0] && !alu_ng && !alu_zr));
    // Jump target and M write address both use A as it was before this instruction
    assign jmp_tgt   = a_q[ADDR_W-1:0];
    assign pc_inc    = pc_q + ADDR_W'(1);
    // A jump onto itself can never make progress, so it is treated as halt
    assign halt_now  = jmp_taken && (jmp_tgt == pc_q);

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StFetch;
            a_q         <= '0;
            d_q         <= '0;
            ir_q        <= '0;
            m_q         <= '0;
            pc_q        <= ResetPc;
            wb_addr_q   <= '0;
            wb_data_q   <= '0;
            halt_pend_q <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            d_q         <= d_d;
            ir_q        <= ir_d;
            m_q         <= m_d;
            pc_q        <= pc_d;
            wb_addr_q   <= wb_addr_d;
            wb_data_q   <= wb_data_d;
            halt_pend_q <= halt_pend_d;
            halted_q    <= halted_d;
        end
    end

    // Next-state, register updates and handshake outputs
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        d_d         = d_q;
        ir_d        = ir_q;
        m_d         = m_q;
        pc_d        = pc_q;
        wb_addr_d   = wb_addr_q;
        wb_data_d   = wb_data_q;
        halt_pend_d = halt_pend_q;
        halted_d    = halted_q;
        instr_req   = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        dmem_addr   = '0;
        dmem_wdata  = '0;
        retire      = 1'b0;

        unique case (state_q)
            StFetch: begin
                instr_req = 1'b1;
                if (instr_ack) begin
                    ir_d    = instr_data;
                    state_d = (instr_data[DATA_W-1] && instr_data[12]) ? StMemRd : StExec;
                end
            end
            StMemRd: begin
                dmem_req  = 1'b1;
                dmem_addr = a_q[ADDR_W-1:0];
                if (dmem_ack) begin
                    m_d     = dmem_rdata;
                    state_d = StExec;
                end
            end
            StExec: begin
                if (!is_c) begin
                    a_d     = {1'b0, ir_q[DATA_W-2:0]};
                    pc_d    = pc_inc;
                    retire  = 1'b1;
                    state_d = StFetch;
                end else begin
                    if (dest_a) a_d = alu_r;
                    if (dest_d) d_d = alu_r;
                    pc_d = jmp_taken ? jmp_tgt : pc_inc;
                    if (dest_m) begin
                        wb_addr_d   = a_q[ADDR_W-1:0];
                        wb_data_d   = alu_r;
                        halt_pend_d = halt_now;
                        state_d     = StMemWr;
                    end else begin
                        retire   = 1'b1;
                        halted_d = halt_now;
                        state_d  = halt_now ? StHalt : StFetch;
                    end
                end
            end
            StMemWr: begin
                dmem_req   = 1'b1;
                dmem_we    = 1'b1;
                dmem_addr  = wb_addr_q;
                dmem_wdata = wb_data_q;
                if (dmem_ack) begin
                    retire   = 1'b1;
                    halted_d = halt_pend_q;
                    state_d  = halt_pend_q ? StHalt : StFetch;
                end
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StFetch;
            end
        endcase

        // While reset is held nothing is requested and nothing completes
        if (reset) begin
            instr_req = 1'b0;
            dmem_req  = 1'b0;
            dmem_we   = 1'b0;
            retire    = 1'b0;
        end
    end

    assign instr_addr = pc_q;
    assign pc_out     = pc_q;
    assign a_out      = a_q;
    assign d_out      = d_q;
    assign halted     = halted_q;

endmodule

// File: tb/tb_hack_cpu_mc.sv
// Scoreboard bench for hack_cpu_mc: an ISA-level model predicts per-instruction state and
// memory writes; a monitor pops predictions as the DUT retires instructions and writes memory.
module tb_hack_cpu_mc;

    localparam int DW    = 16;
    localparam int AW    = 15;
    localparam int MEMSZ = 32768;

    typedef struct {
        int          pc;
        logic [15:0] a;
        logic [15:0] d;
    } exp_t;

    typedef struct {
        int          addr;
        logic [15:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    initial forever #5 clk = ~clk;

    logic          instr_req, instr_ack = 1'b0;
    logic [AW-1:0] instr_addr;
    logic [DW-1:0] instr_data = '0;
    logic          dmem_req, dmem_we, dmem_ack = 1'b0;
    logic [AW-1:0] dmem_addr;
    logic [DW-1:0] dmem_wdata, dmem_rdata = '0;
    logic [AW-1:0] pc_out;
    logic [DW-1:0] a_out, d_out;
    logic          retire, halted;

    hack_cpu_mc u_dut (
        .clk        (clk),
        .reset      (reset),
        .instr_req  (instr_req),
        .instr_addr (instr_addr),
        .instr_ack  (instr_ack),
        .instr_data (instr_data),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata),
        .pc_out     (pc_out),
        .a_out      (a_out),
        .d_out      (d_out),
        .retire     (retire),
        .halted     (halted)
    );

    // Wide-data instance: only checks A-instruction zero extension at 24 bits
    logic          reset2 = 1'b1;
    logic          instr_req2, instr_ack2 = 1'b1;
    logic [AW-1:0] instr_addr2;
    logic [23:0]   instr_data2 = 24'h7FFFFF;
    logic          dmem_req2, dmem_we2, dmem_ack2 = 1'b0;
    logic [AW-1:0] dmem_addr2;
    logic [23:0]   dmem_wdata2, dmem_rdata2 = '0;
    logic [AW-1:0] pc_out2;
    logic [23:0]   a_out2, d_out2;
    logic          retire2, halted2;

    hack_cpu_mc #(.DATA_W(24), .ADDR_W(15), .RESET_PC(0)) u_dut24 (
        .clk        (clk),
        .reset      (reset2),
        .instr_req  (instr_req2),
        .instr_addr (instr_addr2),
        .instr_ack  (instr_ack2),
        .instr_data (instr_data2),
        .dmem_req   (dmem_req2),
        .dmem_we    (dmem_we2),
        .dmem_addr  (dmem_addr2),
        .dmem_wdata (dmem_wdata2),
        .dmem_ack   (dmem_ack2),
        .dmem_rdata (dmem_rdata2),
        .pc_out     (pc_out2),
        .a_out      (a_out2),
        .d_out      (d_out2),
        .retire     (retire2),
        .halted     (halted2)
    );

    logic [15:0] rom  [MEMSZ];
    logic [15:0] ram  [MEMSZ];
    logic [15:0] mram [MEMSZ];
    exp_t exp_q[$];
    wr_t  wr_q[$];

    int n_cmp = 0;
    int n_err = 0;

    // Responder controls: fixed wait (-1 = random 0..3), spurious acks, injected late ack
    int iwait_fixed = -1;
    int dwait_fixed = -1;
    bit spur_en     = 1'b0;
    int inj_cnt     = 0;
    bit mon_en      = 1'b0;
    bit pend        = 1'b0;
    int last_ret_cyc = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] cinst(input logic a, input logic [5:0] c,
                                          input logic [2:0] dst, input logic [2:0] j);
        return {3'b111, a, c, dst, j};
    endfunction

    function automatic logic [15:0] alu_ref(input logic [15:0] ir, input logic [15:0] x_in,
                                            input logic [15:0] y_in);
        logic [15:0] x, y, r;
        x = ir[11] ? 16'h0 : x_in;
        if (ir[10]) x = ~x;
        y = ir[9] ? 16'h0 : y_in;
        if (ir[8]) y = ~y;
        r = ir[7] ? 16'(x + y) : (x & y);
        if (ir[6]) r = ~r;
        return r;
    endfunction

    // ISA-level reference: executes n instructions (or until halt) from PC 0
    task automatic model_run(input int n, output bit halt);
        int          pc, tgt, sr;
        logic [15:0] a, d, ir, r;
        bit          taken;
        exp_t        e;
        wr_t         w;
        pc = 0; a = '0; d = '0; halt = 1'b0;
        for (int i = 0; i < n; i++) begin
            ir = rom[pc];
            if (!ir[15]) begin
                a  = {1'b0, ir[14:0]};
                pc = (pc + 1) % MEMSZ;
            end else begin
                r   = alu_ref(ir, d, ir[12] ? mram[a[14:0]] : a);
                sr  = int'($signed(r));
                tgt = int'(a[14:0]);
                case (ir[2:0])
                    3'd0: taken = 1'b0;
                    3'd1: taken = sr > 0;
                    3'd2: taken = sr == 0;
                    3'd3: taken = sr >= 0;
                    3'd4: taken = sr < 0;
                    3'd5: taken = sr != 0;
                    3'd6: taken = sr <= 0;
                    default: taken = 1'b1;
                endcase
                if (ir[3]) begin
                    mram[tgt] = r;
                    w.addr = tgt; w.data = r;
                    wr_q.push_back(w);
                end
                if (ir[5]) a = r;
                if (ir[4]) d = r;
                if (taken && tgt == pc) halt = 1'b1;
                pc = taken ? tgt : (pc + 1) % MEMSZ;
            end
            e.pc = pc; e.a = a; e.d = d;
            exp_q.push_back(e);
            if (halt) break;
        end
    endtask

    // Memory responder: drives acks on the falling edge
    initial begin
        bit i_busy, d_busy;
        int i_wait, d_wait, inj_done;
        i_busy = 0; d_busy = 0; i_wait = 0; d_wait = 0; inj_done = 0;
        forever begin
            @(negedge clk);
            if (instr_req) begin
                if (!i_busy) begin
                    i_busy = 1;
                    i_wait = (iwait_fixed >= 0) ? iwait_fixed : int'($urandom_range(0, 3));
                end
                if (i_wait == 0) begin
                    instr_ack = 1'b1; instr_data = rom[instr_addr]; i_busy = 0;
                end else begin
                    instr_ack = 1'b0; instr_data = 16'($urandom); i_wait--;
                end
            end else begin
                i_busy = 0; instr_data = 16'($urandom);
                instr_ack = spur_en && ($urandom_range(0, 7) == 0);
            end
            if (dmem_req) begin
                if (!d_busy) begin
                    d_busy = 1;
                    d_wait = (dwait_fixed >= 0) ? dwait_fixed : int'($urandom_range(0, 3));
                end
                if (d_wait == 0) begin
                    dmem_ack = 1'b1; d_busy = 0;
                    if (dmem_we) ram[dmem_addr] = dmem_wdata;
                    else dmem_rdata = ram[dmem_addr];
                end else begin
                    dmem_ack = 1'b0; dmem_rdata = 16'($urandom); d_wait--;
                end
            end else begin
                d_busy = 0; dmem_rdata = 16'($urandom);
                if (inj_cnt != inj_done) begin
                    dmem_ack = 1'b1; inj_done++;
                end else begin
                    dmem_ack = spur_en && ($urandom_range(0, 7) == 0);
                end
            end
        end
    end

    // Monitor: pops the scoreboard on retire and on completed writes
    initial begin
        exp_t          cur;
        wr_t           w;
        bit            d_prev_v, i_prev_v, d_prev_we;
        logic [AW-1:0] d_prev_addr, i_prev_addr;
        logic [15:0]   d_prev_wd;
        int            cyc;
        d_prev_v = 0; i_prev_v = 0; cyc = 0; d_prev_we = 0;
        d_prev_addr = '0; i_prev_addr = '0; d_prev_wd = '0;
        forever begin
            @(negedge clk);
            #1;
            if (reset) begin
                cyc = 0; pend = 0; d_prev_v = 0; i_prev_v = 0;
            end else begin
                cyc++;
                if (mon_en) begin
                    if (instr_req || dmem_req)
                        check("req_exclusive", {31'b0, instr_req && dmem_req}, 32'd0);
                    if (d_prev_v) begin
                        check("dmem_hold_addr", {dmem_req, dmem_addr}, {1'b1, d_prev_addr});
                        check("dmem_hold_data", {dmem_we, dmem_wdata}, {d_prev_we, d_prev_wd});
                    end
                    if (i_prev_v)
                        check("ifetch_hold", {instr_req, instr_addr}, {1'b1, i_prev_addr});
                    if (pend) begin
                        check("pc", 32'(pc_out), cur.pc);
                        check("a_reg", 32'(a_out), 32'(cur.a));
                        check("d_reg", 32'(d_out), 32'(cur.d));
                        pend = 0;
                    end
                    if (dmem_req && dmem_we && dmem_ack) begin
                        if (wr_q.size() == 0) begin
                            check("unexpected_write", 32'd1, 32'd0);
                        end else begin
                            w = wr_q.pop_front();
                            check("wr_addr", 32'(dmem_addr), w.addr);
                            check("wr_data", 32'(dmem_wdata), 32'(w.data));
                        end
                    end
                    if (retire) begin
                        last_ret_cyc = cyc;
                        if (exp_q.size() == 0) begin
                            check("extra_retire", 32'd1, 32'd0);
                        end else begin
                            cur  = exp_q.pop_front();
                            pend = 1;
                        end
                    end
                end
                d_prev_v = dmem_req && !dmem_ack;
                d_prev_addr = dmem_addr; d_prev_we = dmem_we; d_prev_wd = dmem_wdata;
                i_prev_v = instr_req && !instr_ack;
                i_prev_addr = instr_addr;
            end
        end
    end

    task automatic clear_mem();
        for (int i = 0; i < MEMSZ; i++) begin
            rom[i] = '0; ram[i] = '0;
        end
    endtask

    task automatic fill_random();
        logic [15:0] w;
        for (int i = 0; i < MEMSZ; i++) begin
            w = 16'($urandom);
            if ($urandom_range(0, 9) < 4) begin
                w[15] = 1'b0;
                if ($urandom_range(0, 3) != 0) w[14:0] = 15'($urandom_range(0, 63));
            end else begin
                w[15] = 1'b1;
                if ($urandom_range(0, 3) != 0) w[2:0] = 3'd0;
            end
            rom[i] = w;
            ram[i] = 16'($urandom);
        end
    endtask

    // Reset, predict, run until every prediction is consumed, then park in reset
    task automatic run_prog(input string tag, input int n, input int max_cyc);
        bit mhalt;
        int waited, reqs;
        exp_q.delete(); wr_q.delete();
        mon_en = 0; reset = 1'b1;
        for (int i = 0; i < MEMSZ; i++) mram[i] = ram[i];
        model_run(n, mhalt);
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_rst_pc"}, 32'(pc_out), 32'd0);
        check({tag, "_rst_ad"}, {a_out, d_out}, 32'd0);
        check({tag, "_rst_ctl"}, {27'b0, instr_req, dmem_req, dmem_we, retire, halted}, 32'd0);
        reset = 1'b0; mon_en = 1;
        #1;
        check({tag, "_first_req"}, {31'b0, instr_req}, 32'd1);
        waited = 0;
        while ((exp_q.size() != 0 || pend) && waited < max_cyc) begin
            @(posedge clk);
            #1;
            waited++;
        end
        check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_writes_done"}, 32'(wr_q.size()), 32'd0);
        check({tag, "_halted"}, {31'b0, halted}, {31'b0, mhalt});
        if (mhalt) begin
            reqs = 0;
            repeat (20) begin
                @(posedge clk);
                #1;
                if (instr_req || dmem_req) reqs++;
            end
            check({tag, "_halt_quiet"}, 32'(reqs), 32'd0);
        end
        mon_en = 0; reset = 1'b1;
    endtask

    initial begin
        int waited;
        // Zero-wait straight-line program with a single M write
        iwait_fixed = 0; dwait_fixed = 0; spur_en = 0;
        clear_mem();
        rom[0] = 16'd5;
        rom[1] = cinst(1'b0, 6'b110000, 3'b010, 3'b000);
        rom[2] = 16'd7;
        rom[3] = cinst(1'b0, 6'b001100, 3'b001, 3'b000);
        run_prog("straight", 4, 40);
        check("straight_cycles", 32'(last_ret_cyc), 32'd9);

        // Read-modify-write with a slow data memory
        iwait_fixed = 0; dwait_fixed = 3;
        clear_mem();
        rom[0] = 16'd100;
        rom[1] = cinst(1'b1, 6'b110111, 3'b001, 3'b000);
        ram[100] = 16'd41;
        run_prog("rmw_slow", 2, 60);

        // AM=M-1: write address uses A before the update
        iwait_fixed = 0; dwait_fixed = 0;
        clear_mem();
        rom[0] = 16'd3;
        rom[1] = cinst(1'b1, 6'b110010, 3'b101, 3'b000);
        ram[3] = 16'd9;
        run_prog("am_dec", 2, 40);

        // Conditional jumps: JEQ taken, JEQ not taken, JLT on negative
        clear_mem();
        rom[0]  = 16'd0;
        rom[1]  = cinst(1'b0, 6'b110000, 3'b010, 3'b000);
        rom[2]  = 16'd10;
        rom[3]  = cinst(1'b0, 6'b001100, 3'b000, 3'b010);
        rom[10] = 16'd1;
        rom[11] = cinst(1'b0, 6'b110000, 3'b010, 3'b000);
        rom[12] = 16'd20;
        rom[13] = cinst(1'b0, 6'b001100, 3'b000, 3'b010);
        rom[14] = cinst(1'b0, 6'b111010, 3'b010, 3'b000);
        rom[15] = 16'd30;
        rom[16] = cinst(1'b0, 6'b001100, 3'b000, 3'b100);
        run_prog("jumps", 11, 80);

        // Self-jump halts
        clear_mem();
        rom[0] = 16'd1;
        rom[1] = 16'd2;
        rom[2] = 16'd3;
        rom[3] = cinst(1'b0, 6'b110000, 3'b010, 3'b000);
        rom[4] = 16'd5;
        rom[5] = cinst(1'b0, 6'b101010, 3'b000, 3'b111);
        run_prog("halt", 10, 80);

        // Random programs with random waits and spurious acks
        iwait_fixed = -1; dwait_fixed = -1; spur_en = 1;
        for (int r = 0; r < 3; r++) begin
            fill_random();
            run_prog($sformatf("rand%0d", r), 300, 300 * 14);
        end

        // Reset during an M read wait; a late ack must be ignored
        iwait_fixed = 0; dwait_fixed = 1000; spur_en = 0;
        clear_mem();
        rom[0] = 16'd100;
        rom[1] = cinst(1'b1, 6'b110000, 3'b010, 3'b000);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        waited = 0;
        while (!dmem_req && waited < 20) begin
            @(posedge clk);
            #1;
            waited++;
        end
        check("rst_mrd_addr", {dmem_req, dmem_addr}, {1'b1, 15'd100});
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mrd_dreq", {31'b0, dmem_req}, 32'd0);
        check("rst_mrd_pc", 32'(pc_out), 32'd0);
        reset = 1'b0;
        inj_cnt++;
        repeat (4) @(posedge clk);
        #1;
        check("rst_late_ack_state", {dmem_req, dmem_we, dmem_addr}, {1'b1, 1'b0, 15'd100});
        check("rst_late_ack_ad", {a_out, d_out}, {16'd100, 16'd0});
        reset = 1'b1;

        // 24-bit datapath: A-instruction 0x7FFFFF
        @(posedge clk);
        #1;
        reset2 = 1'b0;
        waited = 0;
        while (!retire2 && waited < 10) begin
            @(negedge clk);
            #1;
            waited++;
        end
        check("w24_retired", {31'b0, retire2}, 32'd1);
        @(posedge clk);
        #1;
        check("w24_a", 32'(a_out2), 32'h7FFFFF);
        check("w24_pc", 32'(pc_out2), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hack_cpu_mc.md
HACK_CPU_MC -- requirements
Module: hack_cpu_mc

Interface
REQ-001 Parameter DATA_W, default 16: width of A, D, ALU and data-memory words; legal range 16..32.
REQ-002 Parameter ADDR_W, default 15: width of PC, instruction address and data address; ADDR_W < DATA_W.
REQ-003 Parameter RESET_PC, default 0: PC value loaded on reset.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 instr_req  output  1  instruction fetch request.
REQ-008 instr_addr  output  ADDR_W  fetch address, equals PC.
REQ-009 instr_ack  input  1  fetch complete; instr_data valid this cycle.
REQ-010 instr_data  input  DATA_W  fetched instruction word.
REQ-011 dmem_req  output  1  data-memory request.
REQ-012 dmem_we  output  1  1 = write, 0 = read; valid while dmem_req=1.
REQ-013 dmem_addr  output  ADDR_W  data address.
REQ-014 dmem_wdata  output  DATA_W  write data.
REQ-015 dmem_ack  input  1  data transfer complete; dmem_rdata valid on reads.
REQ-016 dmem_rdata  input  DATA_W  read data.
REQ-017 pc_out  output  ADDR_W  current PC.
REQ-018 a_out, d_out  output  DATA_W each  current A and D register values.
REQ-019 retire  output  1  one-cycle pulse per completed instruction.
REQ-020 halted  output  1  set by halt detection, cleared only by reset.

Function
REQ-021 Encoding: MSB=0 -> A-instruction, A <= zero-extended instr[DATA_W-2:0]; MSB=1 -> C-instruction, with a=bit12, zx..no=bits11..6, dest A/D/M=bits5/4/3, jump=bits2..0; bits DATA_W-2..13 ignored.
REQ-022 The ALU computes the standard zx/nx/zy/ny/f/no function at DATA_W bits, with x=D and y = A (a=0) or M (a=1); add wraps modulo 2^DATA_W; zr = (result==0); ng = result MSB.
REQ-023 Jump condition per bits2..0: 000 never, 001 GT, 010 EQ, 011 GE, 100 LT, 101 NE, 110 LE, 111 always.
REQ-024 FSM states: FETCH, MEM_RD, EXEC, MEM_WR, HALT.
REQ-025 FETCH: instr_req=1. On instr_ack, latch IR and go to MEM_RD if C-instruction with a=1, else EXEC.
REQ-026 MEM_RD: dmem_req=1, dmem_we=0, dmem_addr=A[ADDR_W-1:0]. On dmem_ack, latch M and go to EXEC.
REQ-027 EXEC (one cycle): commit A/D per dest; PC <= A_old[ADDR_W-1:0] if jump is taken, else PC+1 modulo 2^ADDR_W.
REQ-028 EXEC, dest M: also latch wb_addr=A_old[ADDR_W-1:0] and wb_data=ALU result, then go to MEM_WR; otherwise pulse retire and go to FETCH (or HALT per REQ-031).
REQ-029 MEM_WR: dmem_req=1, dmem_we=1, dmem_addr=wb_addr, dmem_wdata=wb_data. On dmem_ack, pulse retire and go to FETCH or HALT.
REQ-030 Simultaneous dest A and M, or a jump with dest A: M address and jump target SHALL use the pre-instruction A value.
REQ-031 Halt: a taken jump whose target equals the PC of the jumping instruction sets halted=1 on completion; HALT issues no requests; only reset exits HALT.
REQ-032 Handshake: req, addr, we and wdata are held stable until ack is sampled high. An ack in the same cycle req first rises completes the transfer. Ack while the matching req is low is ignored. instr_req and dmem_req are never high together.
REQ-033 Zero-wait latency (ack in the req cycle): A-instruction or C-instruction without M takes 2 cycles; M read only or M write only takes 3; M read+write takes 4. Each wait cycle adds 1.
REQ-034 retire: exactly one pulse per instruction, coincident with its final state cycle.

Reset
REQ-035 On reset: A=0, D=0, IR=0, PC=RESET_PC, state=FETCH, halted=0, retire=0, instr_req/dmem_req/dmem_we=0 in the following cycle.
REQ-036 Reset overrides any in-flight handshake; no write completes after reset; a late ack arriving after reset is ignored.
REQ-037 instr_req rises in the first cycle after reset deasserts.

Verification
REQ-038 Zero-wait program @5; D=A; @7; M=D -> one write, addr 7 data 5; 4 retire pulses in 9 cycles; pc_out=4.
REQ-039 A=100, instruction M=M+1, dmem_rdata=41 with ack delayed 3 cycles -> read addr 100 held stable; then write addr 100 data 42.
REQ-040 A=3, M=9, instruction AM=M-1 -> write addr 3 data 8; a_out=8 afterwards.
REQ-041 D=0; @10; D;JEQ -> PC=10. D=1; @10; D;JEQ -> PC=PC+1. D=0xFFFF; D;JLT -> taken.
REQ-042 @5 at PC 4, 0;JMP at PC 5 -> halted=1; no instr_req thereafter until reset.
REQ-043 Reset asserted during a MEM_RD wait, ack 2 cycles later -> dmem_req=0 next cycle, pc_out=RESET_PC, ack ignored. With DATA_W=24, A-instruction 0x7FFFFF -> a_out=0x7FFFFF.
